lamp_scheduler: RTL and testbench
=================================

# lamp_scheduler

Sequencing controller for the tail-light LED bank. Arbitrates left-turn, right-turn and hazard requests from switches and keys, and runs the selected animation one step per divided-clock tick. Drives the 10-bit LED bar and a 4-bit state code for the HEX decoder. Sits between the clock divider / input pins and the LEDR/HEX outputs, and replaces the ad-hoc next-state, counter and output glue.

## Interface
- `STEP_TICKS`, default 1: `tick` pulses per animation step; legal range 1..15.
- `clock` input, 1 bit: system clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `tick` input, 1 bit: single-cycle enable from the clock divider; all state advances only on it.
- `req_left` input, 1 bit: left-turn request (level).
- `req_right` input, 1 bit: right-turn request (level).
- `req_hazard` input, 1 bit: hazard request (level).
- `req_brake` input, 1 bit: brake request (level); present only with `LAMP_BRAKE_EN`.
- `ledr` output, 10 bits: lamp pattern; left group [9:7], right group [2:0], centre [6:3].
- `state_code` output, 4 bits: 0 = IDLE, 1 = LEFT, 2 = RIGHT, 3 = HAZARD.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- States: IDLE, LEFT, RIGHT, HAZARD. There is a 2-bit step counter `step` and an internal prescale counter.
- A step event is a `tick` on which the prescale counter reaches `STEP_TICKS-1`. The prescaler then wraps to 0.
- Arbitration priority:
  - `req_hazard`, or `req_left && req_right`, selects HAZARD.
  - Otherwise `req_left` selects LEFT.
  - Otherwise `req_right` selects RIGHT.
  - Otherwise IDLE.
- Arbitration is evaluated at:
  - every step event while in IDLE;
  - the step event that ends a sweep (LEFT/RIGHT with `step==3`);
  - every step event while in HAZARD.
- Pre-emption: in LEFT/RIGHT, a step event with a hazard condition goes to HAZARD with `step=0` immediately, without finishing the sweep. A turn never pre-empts another turn.
- Turn sweep: active group shows 001, 011, 111, 000 for `step` 0..3. Left group is mirrored: 100, 110, 111, 000. The inactive group is 000.
- After `step==3`, if the same request is still high, the sweep restarts at step 0. If not, arbitration picks the next state.
- HAZARD: both groups 111 when `step[0]==0`, 000 when `step[0]==1`. The counter runs 0..3 and wraps.
- Leaving HAZARD takes effect at any step event where the hazard condition is false.
- Entering any non-IDLE state sets `step=0`. IDLE holds `step=0` and `ledr=0`.
- Requests are sampled only at step events. A pulse shorter than one step is allowed to be missed.

## Timing
- Reset (asynchronous): state IDLE, `step=0`, prescaler 0, `ledr=0`, `state_code=0`, `busy=0`.
- All outputs are registered and update on the clock edge that consumes the step event. Latency from a step event to the new `ledr` is 1 clock.
- Between step events all outputs hold.
- `tick` high on consecutive clocks counts each clock as a separate tick.
- Reset asserted mid-sweep clears everything immediately. After release, the first step event arbitrates from IDLE.

## Configuration
- `LAMP_BRAKE_EN` defined:
  - The `req_brake` port exists.
  - While it is high, centre `ledr[6:3]=1111`, and in LEFT/RIGHT the inactive group is forced to 111.
  - The brake overlay is combinational on the registered state and takes effect one clock after `req_brake` is registered. It does not wait for `tick`.
  - In HAZARD, brake affects only the centre bits.
- Not defined: no port, and `ledr[6:3]` is constant 0.

## Structure
- Shared package `lamp_pkg`:
  - state enum with the encodings listed for `state_code`;
  - sweep pattern constants (`SWEEP_R[0:3]`, `SWEEP_L[0:3]`);
  - group bit-position constants.
- One sub-module, `lamp_step_timer`: the prescale counter. It takes `clock`, `reset_n`, `tick` and `STEP_TICKS`, and outputs the `step_evt` pulse.

## Test plan
- Reset, `STEP_TICKS=1`, `req_left=1` held 8 ticks -> `ledr[9:7]` = 100, 110, 111, 000, 100, … and `state_code=1`.
- LEFT at step 1, then `req_hazard=1` -> next step event gives `state_code=3` and `ledr=10'b1110000111`; the following event gives `ledr=0`.
- `req_right=1` at step 1, then `req_left=1` raised with `req_right` dropped -> RIGHT completes steps 2 and 3, then LEFT starts at 100.
- `req_left=req_right=1` from IDLE -> HAZARD on the first step event.
- `STEP_TICKS=3` -> `ledr` changes every third tick. `reset_n` pulsed low mid-sweep -> `ledr=0` the same cycle, and `busy=0`.
- With `LAMP_BRAKE_EN`, RIGHT plus `req_brake=1` -> `ledr[9:3]=1111111`, right group still sweeping.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared types and constants for the tail-light sequencer.
package lamp_pkg;

  localparam int unsigned LED_W        = 10;
  localparam int unsigned STATE_CODE_W = 4;
  localparam int unsigned STEP_W       = 2;
  localparam int unsigned GRP_W        = 3;
  localparam int unsigned CENTRE_W     = 4;

  // Bit positions of the three lamp groups on the LED bar
  localparam int unsigned LEFT_LSB   = 7;
  localparam int unsigned CENTRE_LSB = 3;
  localparam int unsigned RIGHT_LSB  = 0;

  // Encodings double as the HEX state code
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } lamp_state_e;

  // Sweep patterns per step; the left group is the mirror image of the right
  localparam logic [GRP_W-1:0] SWEEP_R [0:3] = '{3'b001, 3'b011, 3'b111, 3'b000};
  localparam logic [GRP_W-1:0] SWEEP_L [0:3] = '{3'b100, 3'b110, 3'b111, 3'b000};

  // Lamp pattern implied by state and step, before any brake overlay
  function automatic logic [LED_W-1:0] base_pattern(input lamp_state_e st,
                                                    input logic [STEP_W-1:0] stp);
    logic [LED_W-1:0] p;
    p = '0;
    case (st)
      ST_LEFT:  p[LEFT_LSB +: GRP_W]  = SWEEP_L[stp];
      ST_RIGHT: p[RIGHT_LSB +: GRP_W] = SWEEP_R[stp];
      ST_HAZARD: begin
        if (!stp[0]) begin
          p[LEFT_LSB +: GRP_W]  = '1;
          p[RIGHT_LSB +: GRP_W] = '1;
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lamp_step_timer.sv
// Prescaler: turns divider ticks into animation step events (one per STEP_TICKS ticks).
module lamp_step_timer #(
  parameter int unsigned STEP_TICKS = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  output logic step_evt
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  // Event fires in the same cycle as the tick that completes the count
  assign step_evt = tick && (cnt == LAST);

  // Count ticks, wrapping to zero on the step event
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lamp_scheduler.sv
// Tail-light sequencer: arbitrates turn/hazard requests and steps the lamp animation.
// Optional brake overlay and req_brake port enabled by defining LAMP_BRAKE_EN.
module lamp_scheduler
  import lamp_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    req_left,
  input  logic                    req_right,
  input  logic                    req_hazard,
`ifdef LAMP_BRAKE_EN
  input  logic                    req_brake,
`endif
  output logic [LED_W-1:0]        ledr,
  output logic [STATE_CODE_W-1:0] state_code,
  output logic                    busy
);

  logic              step_evt;
  lamp_state_e       state;
  lamp_state_e       state_nx;
  lamp_state_e       arb_c;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_nx;
  logic              hz_c;

  lamp_step_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .step_evt(step_evt)
  );

  // Request priority: hazard (or both turns) over left over right
  always_comb begin
    hz_c = req_hazard | (req_left & req_right);
    if (hz_c) begin
      arb_c = ST_HAZARD;
    end else if (req_left) begin
      arb_c = ST_LEFT;
    end else if (req_right) begin
      arb_c = ST_RIGHT;
    end else begin
      arb_c = ST_IDLE;
    end
  end

  // Next state/step; only a step event can move the machine
  always_comb begin
    state_nx = state;
    step_nx  = step;
    if (step_evt) begin
      case (state)
        ST_IDLE: begin
          state_nx = arb_c;
          step_nx  = '0;
        end
        ST_LEFT, ST_RIGHT: begin
          if (hz_c) begin
            state_nx = ST_HAZARD;
            step_nx  = '0;
          end else if (step == STEP_W'(3)) begin
            // Still-held request re-wins arbitration, restarting the sweep
            state_nx = arb_c;
            step_nx  = '0;
          end else begin
            step_nx = step + STEP_W'(1);
          end
        end
        ST_HAZARD: begin
          if (hz_c) begin
            step_nx = step + STEP_W'(1);
          end else begin
            state_nx = arb_c;
            step_nx  = '0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          step_nx  = '0;
        end
      endcase
    end
  end

  // State and step registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      step  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

`ifdef LAMP_BRAKE_EN
  logic brake_q;

  // Brake level is registered every clock, independent of tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      brake_q <= 1'b0;
    end else begin
      brake_q <= req_brake;
    end
  end

  // Animation pattern with brake overlay on centre and idle turn group
  always_comb begin
    ledr = base_pattern(state, step);
    if (brake_q) begin
      ledr[CENTRE_LSB +: CENTRE_W] = '1;
      if (state == ST_LEFT) begin
        ledr[RIGHT_LSB +: GRP_W] = '1;
      end else if (state == ST_RIGHT) begin
        ledr[LEFT_LSB +: GRP_W] = '1;
      end
    end
  end
`else
  // Animation pattern straight from the registered state and step
  always_comb begin
    ledr = base_pattern(state, step);
  end
`endif

  assign state_code = STATE_CODE_W'(state);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_lamp_scheduler.sv
// Directed bench for lamp_scheduler: STEP_TICKS=1 and STEP_TICKS=3 instances share stimulus.
module tb_lamp_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       req_left;
  logic       req_right;
  logic       req_hazard;
`ifdef LAMP_BRAKE_EN
  logic       req_brake;
`endif
  logic [9:0] ledr1;
  logic [3:0] code1;
  logic       busy1;
  logic [9:0] ledr3;
  logic [3:0] code3;
  logic       busy3;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       l;
    logic       r;
    logic       h;
    logic [9:0] led;
    logic [3:0] code;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  always #5 clock = ~clock;

  lamp_scheduler #(.STEP_TICKS(1)) u_dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick),
    .req_left  (req_left),
    .req_right (req_right),
    .req_hazard(req_hazard),
`ifdef LAMP_BRAKE_EN
    .req_brake (req_brake),
`endif
    .ledr      (ledr1),
    .state_code(code1),
    .busy      (busy1)
  );

  lamp_scheduler #(.STEP_TICKS(3)) u_dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .tick      (tick),
    .req_left  (req_left),
    .req_right (req_right),
    .req_hazard(req_hazard),
`ifdef LAMP_BRAKE_EN
    .req_brake (req_brake),
`endif
    .ledr      (ledr3),
    .state_code(code3),
    .busy      (busy3)
  );

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // One tick with the given requests; outputs sampled 1 time unit after the edge
  task automatic do_tick(input logic l, input logic r, input logic h);
    req_left   = l;
    req_right  = r;
    req_hazard = h;
    tick       = 1'b1;
    @(posedge clock);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // {left, right, hazard, expected ledr, expected state_code} for STEP_TICKS=1
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'b1100000000, 4'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'b1110000000, 4'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 10'b0000000000, 4'd1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'b1100000000, 4'd1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 10'b1110000111, 4'd3};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 10'b0000000000, 4'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'b1110000111, 4'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'b0000000000, 4'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10'b0000000001, 4'd2};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 10'b0000000011, 4'd2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10'b0000000111, 4'd2};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 10'b0000000000, 4'd2};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 10'b1100000000, 4'd1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 10'b1110000000, 4'd1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 10'b0000000000, 4'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 10'b0000000000, 4'd0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 10'b1110000111, 4'd3};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 10'b0000000000, 4'd0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd1};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 10'b1100000000, 4'd1};

    req_left   = 1'b0;
    req_right  = 1'b0;
    req_hazard = 1'b0;
`ifdef LAMP_BRAKE_EN
    req_brake  = 1'b0;
`endif
    do_reset();

    // Reset state
    check("reset ledr1", ledr1, 10'd0);
    check("reset code1", 10'(code1), 10'd0);
    check("reset busy1", 10'(busy1), 10'd0);
    check("reset ledr3", ledr3, 10'd0);

    // Table-driven sequence, one step event per tick
    for (int i = 0; i < NVEC; i++) begin
      do_tick(vecs[i].l, vecs[i].r, vecs[i].h);
      check($sformatf("vec%0d ledr", i), ledr1, vecs[i].led);
      check($sformatf("vec%0d code", i), 10'(code1), 10'(vecs[i].code));
      check($sformatf("vec%0d busy", i), 10'(busy1), 10'(vecs[i].code != 4'd0));
    end

    // Outputs hold between ticks even with a hazard request present
    req_hazard = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("hold ledr", ledr1, 10'b1100000000);
    check("hold code", 10'(code1), 10'd1);
    req_hazard = 1'b0;

    // STEP_TICKS=3: ledr only changes on every third tick
    do_reset();
    do_tick(1'b1, 1'b0, 1'b0);
    check("pre t1 ledr3", ledr3, 10'd0);
    check("pre t1 ledr1", ledr1, 10'b1000000000);
    do_tick(1'b1, 1'b0, 1'b0);
    check("pre t2 ledr3", ledr3, 10'd0);
    check("pre t2 code3", 10'(code3), 10'd0);
    do_tick(1'b1, 1'b0, 1'b0);
    check("pre t3 ledr3", ledr3, 10'b1000000000);
    check("pre t3 code3", 10'(code3), 10'd1);
    do_tick(1'b1, 1'b0, 1'b0);
    do_tick(1'b1, 1'b0, 1'b0);
    check("pre t5 ledr3", ledr3, 10'b1000000000);
    do_tick(1'b1, 1'b0, 1'b0);
    check("pre t6 ledr3", ledr3, 10'b1100000000);

    // Asynchronous reset mid-sweep clears outputs before any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst ledr3", ledr3, 10'd0);
    check("async rst busy3", 10'(busy3), 10'd0);
    check("async rst ledr1", ledr1, 10'd0);
    check("async rst code1", 10'(code1), 10'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // After release the prescaler restarts and arbitrates from IDLE
    do_tick(1'b0, 1'b1, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0);
    check("post rst t2 ledr3", ledr3, 10'd0);
    do_tick(1'b0, 1'b1, 1'b0);
    check("post rst t3 ledr3", ledr3, 10'b0000000001);
    check("post rst t3 code3", 10'(code3), 10'd2);

`ifdef LAMP_BRAKE_EN
    // Brake overlay on a right sweep: left group and centre lit, right keeps sweeping
    do_reset();
    req_brake = 1'b1;
    do_tick(1'b0, 1'b1, 1'b0);
    check("brake s0 ledr", ledr1, 10'b1111111001);
    do_tick(1'b0, 1'b1, 1'b0);
    check("brake s1 ledr", ledr1, 10'b1111111011);
    req_brake = 1'b0;
    @(posedge clock);
    #1;
    check("brake off ledr", ledr1, 10'b0000000011);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
